// File: rtl/window_fetch_ctrl_pkg.sv
// Shared constants and FSM encoding for the 3x3 window fetch controller.
// Package name is cnn_layer_pkg so other layer blocks can share it.
package cnn_layer_pkg;

    localparam int IMG_W  = 80;
    localparam int IMG_H  = 60;
    localparam int ADDR_W = 13;
    localparam int KSIZE  = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_OUT   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/window_fetch_ctrl_if.sv
// Bus bundle for window_fetch_ctrl: frame control, pixel-memory read port
// and the window output stream.
//
// Window stream handshake: a window transfers on every rising edge where
// win_valid and win_ready are both high. Once win_valid is raised it stays
// high, and win_data/win_row/win_col stay unchanged, until that transfer.
// win_ready may change freely and must not depend on win_valid.
interface window_fetch_ctrl_if #(
    parameter int ADDR_W = cnn_layer_pkg::ADDR_W
);

    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              busy;
    logic              done;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [7:0]        mem_rd_data;
    logic              win_valid;
    logic              win_ready;
    logic [71:0]       win_data;
    logic [5:0]        win_row;
    logic [6:0]        win_col;

    // Controller side.
    modport master (
        input  start, base_addr, mem_rd_data, win_ready,
        output busy, done, mem_rd_en, mem_rd_addr,
               win_valid, win_data, win_row, win_col
    );

    // Environment side: requester, pixel memory and window consumer.
    modport slave (
        output start, base_addr, mem_rd_data, win_ready,
        input  busy, done, mem_rd_en, mem_rd_addr,
               win_valid, win_data, win_row, win_col
    );

endinterface

// File: rtl/window_fetch_ctrl_tap_address_gen.sv
// Combinational tap address: ref + r*IMG_W + c for tap k = 3*r + c,
// wrapping modulo 2^ADDR_W.
module tap_address_gen #(
    parameter int IMG_W  = cnn_layer_pkg::IMG_W,
    parameter int ADDR_W = cnn_layer_pkg::ADDR_W
) (
    input  logic [ADDR_W-1:0] ref_addr,
    input  logic [3:0]        k,
    output logic [ADDR_W-1:0] tap_addr
);
    import cnn_layer_pkg::*;

    logic [3:0] tap_r;
    logic [3:0] tap_c;

    // Split the tap index into row/column and add the offsets to the reference.
    always_comb begin
        tap_r    = k / 4'(KSIZE);
        tap_c    = k % 4'(KSIZE);
        tap_addr = ref_addr + ADDR_W'(int'(tap_r) * IMG_W) + ADDR_W'(tap_c);
    end

endmodule

// File: rtl/window_fetch_ctrl.sv
// Scans one frame as a raster of 3x3 windows, reading pixels from a
// single-cycle-latency memory and presenting each window on a valid/ready
// stream. Optional macro WINDOW_COLUMN_REUSE_EN keeps two columns of the
// previous window when stepping right, so only the new column is read.
module window_fetch_ctrl #(
    parameter int IMG_W  = cnn_layer_pkg::IMG_W,
    parameter int IMG_H  = cnn_layer_pkg::IMG_H,
    parameter int ADDR_W = cnn_layer_pkg::ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    window_fetch_ctrl_if.master   bus,
    output cnn_layer_pkg::state_t state_dbg
);
    import cnn_layer_pkg::*;

    localparam logic [6:0] COL_LAST      = 7'(IMG_W - KSIZE);
    localparam logic [5:0] ROW_LAST      = 6'(IMG_H - KSIZE);
    localparam logic [3:0] IDX_FULL_LAST = 4'(KSIZE * KSIZE - 1);
    localparam logic [3:0] IDX_COL_LAST  = 4'(KSIZE - 1);

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] base_q;
    logic [5:0]        row;
    logic [6:0]        col;
    logic [3:0]        fetch_idx;
    logic [3:0]        tap_k;
    logic              full_fetch;
    logic              fetch_last;
    logic              accept;
    logic              last_win;
    logic [ADDR_W-1:0] ref_addr;
    logic [ADDR_W-1:0] tap_addr;
    logic              cap_en;
    logic [3:0]        cap_k;
    logic [71:0]       win_buf;

`ifdef WINDOW_COLUMN_REUSE_EN
    // Only the first window of a row needs all nine taps.
    assign full_fetch = (col == 7'd0);
`else
    assign full_fetch = 1'b1;
`endif

    assign tap_k      = full_fetch ? fetch_idx : fetch_idx * 4'(KSIZE) + 4'(KSIZE - 1);
    assign fetch_last = (fetch_idx == (full_fetch ? IDX_FULL_LAST : IDX_COL_LAST));
    assign accept     = (state == ST_OUT) && bus.win_ready;
    assign last_win   = (row == ROW_LAST) && (col == COL_LAST);
    assign ref_addr   = ADDR_W'(int'(base_q) + int'(row) * IMG_W + int'(col));

    tap_address_gen #(
        .IMG_W  (IMG_W),
        .ADDR_W (ADDR_W)
    ) u_tap_addr (
        .ref_addr (ref_addr),
        .k        (tap_k),
        .tap_addr (tap_addr)
    );

    assign bus.busy        = (state != ST_IDLE);
    assign bus.done        = (state == ST_DONE);
    assign bus.win_valid   = (state == ST_OUT);
    assign bus.mem_rd_en   = (state == ST_FETCH);
    assign bus.mem_rd_addr = (state == ST_FETCH) ? tap_addr : '0;
    assign bus.win_data    = win_buf;
    assign bus.win_row     = row;
    assign bus.win_col     = col;
    assign state_dbg       = state;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // Next-state decode; start is only honoured in IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (bus.start) state_nx = ST_FETCH;
            ST_FETCH: if (fetch_last) state_nx = ST_WAIT;
            ST_WAIT:  state_nx = ST_OUT;
            ST_OUT:   if (bus.win_ready) state_nx = last_win ? ST_DONE : ST_FETCH;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Scan position, read sequencing and window capture (data lands one cycle after its read).
    always_ff @(posedge clk) begin
        if (reset) begin
            base_q    <= '0;
            row       <= '0;
            col       <= '0;
            fetch_idx <= '0;
            cap_en    <= 1'b0;
            cap_k     <= '0;
            win_buf   <= '0;
        end else begin
            cap_en <= (state == ST_FETCH);
            cap_k  <= tap_k;
            if (cap_en) win_buf[{cap_k, 3'b000} +: 8] <= bus.mem_rd_data;

            if (state == ST_IDLE && bus.start) begin
                base_q    <= bus.base_addr;
                row       <= '0;
                col       <= '0;
                fetch_idx <= '0;
            end

            if (state == ST_FETCH) fetch_idx <= fetch_idx + 4'd1;

            if (accept) begin
                fetch_idx <= '0;
                if (!last_win) begin
                    if (col == COL_LAST) begin
                        col <= '0;
                        row <= row + 6'd1;
                    end else begin
                        col <= col + 7'd1;
                    end
                end
`ifdef WINDOW_COLUMN_REUSE_EN
                // Slide left one column; a new row refetches all taps anyway.
                for (int r = 0; r < KSIZE; r++) begin
                    win_buf[8*(3*r)   +: 8] <= win_buf[8*(3*r+1) +: 8];
                    win_buf[8*(3*r+1) +: 8] <= win_buf[8*(3*r+2) +: 8];
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_window_fetch_ctrl.sv
// Testbench for window_fetch_ctrl: random pixel memory, random consumer
// back-pressure, and a frame-level reference model feeding expected read
// addresses and windows into queues checked by a negedge monitor.
`timescale 1ns/1ps
module tb_window_fetch_ctrl;
    import cnn_layer_pkg::*;

    localparam int W    = IMG_W;
    localparam int H    = IMG_H;
    localparam int AW   = ADDR_W;
    localparam int NWIN = (W - 2) * (H - 2);
`ifdef WINDOW_COLUMN_REUSE_EN
    localparam bit REUSE    = 1'b1;
    localparam int EXP_DONE = 22968;
    int exp_second[$] = '{3, 83, 163};
`else
    localparam bit REUSE    = 1'b0;
    localparam int EXP_DONE = 49764;
    int exp_second[$] = '{1, 2, 3, 81, 82, 83, 161, 162, 163};
`endif
    int exp_first[9] = '{0, 1, 2, 80, 81, 82, 160, 161, 162};
    int exp_wrap[6]  = '{8190, 8191, 0, 78, 79, 80};

    // ---------------- clock / reset ----------------
    logic   clk = 1'b0;
    logic   reset;
    state_t state_dbg;

    always #5 clk = ~clk;

    window_fetch_ctrl_if #(.ADDR_W(AW)) bus ();

    window_fetch_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.master),
        .state_dbg (state_dbg)
    );

    // ---------------- pixel memory ----------------
    logic [7:0] mem [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];
        else               bus.mem_rd_data <= 8'($urandom);
    end

    // ---------------- scoreboard ----------------
    logic [71:0]   exp_data_q[$];
    logic [12:0]   exp_pos_q[$];
    logic [AW-1:0] exp_addr_q[$];
    logic [AW-1:0] rd_log[$];
    logic [12:0]   last_pos;
    int checks = 0;
    int errors = 0;
    int win_cnt = 0;
    int done_cnt = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic flush_expect();
        exp_data_q.delete();
        exp_pos_q.delete();
        exp_addr_q.delete();
    endtask

    // Reference: every window of the frame in raster order, with its reads.
    task automatic model_frame(input logic [AW-1:0] base);
        int refa;
        int tap;
        logic [71:0] d;
        logic [5:0] r6;
        logic [6:0] c7;
        for (int r = 0; r <= H - 3; r++) begin
            for (int c = 0; c <= W - 3; c++) begin
                refa = int'(base) + r * W + c;
                d = '0;
                for (int k = 0; k < 9; k++) begin
                    tap = (refa + (k / 3) * W + (k % 3)) % (1 << AW);
                    d[8*k +: 8] = mem[tap];
                    if (!REUSE || c == 0 || (k % 3) == 2) exp_addr_q.push_back(AW'(tap));
                end
                r6 = 6'(r);
                c7 = 7'(c);
                exp_data_q.push_back(d);
                exp_pos_q.push_back({r6, c7});
            end
        end
    endtask

    // Monitor: every read and every accepted window against the queues.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (bus.mem_rd_en === 1'b1) begin
                if (rd_log.size() < 32) rd_log.push_back(bus.mem_rd_addr);
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_addr actual=%0d required=no_read", bus.mem_rd_addr);
                end else begin
                    check("rd_addr", 72'(bus.mem_rd_addr), 72'(exp_addr_q.pop_front()));
                end
            end
            if (bus.win_valid === 1'b1 && bus.win_ready === 1'b1) begin
                win_cnt++;
                last_pos = {bus.win_row, bus.win_col};
                if (exp_data_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL win_extra actual_row=%0d actual_col=%0d required=none", bus.win_row, bus.win_col);
                end else begin
                    check("win_data", bus.win_data, exp_data_q.pop_front());
                    check("win_pos", 72'({bus.win_row, bus.win_col}), 72'(exp_pos_q.pop_front()));
                end
            end
            if (bus.done === 1'b1) done_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_frame(input logic [AW-1:0] base);
        rd_log.delete();
        win_cnt  = 0;
        done_cnt = 0;
        model_frame(base);
        bus.base_addr = base;
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.start     = 1'b0;
        bus.base_addr = AW'($urandom);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"},  72'(bus.busy), 72'(0));
        check({tag, "_done"},  72'(bus.done), 72'(0));
        check({tag, "_rd_en"}, 72'(bus.mem_rd_en), 72'(0));
        check({tag, "_valid"}, 72'(bus.win_valid), 72'(0));
        check({tag, "_addr"},  72'(bus.mem_rd_addr), 72'(0));
        check({tag, "_data"},  bus.win_data, 72'(0));
        check({tag, "_row"},   72'(bus.win_row), 72'(0));
        check({tag, "_col"},   72'(bus.win_col), 72'(0));
        check({tag, "_state"}, 72'(state_dbg), 72'(ST_IDLE));
    endtask

    task automatic apply_reset(input string tag);
        reset = 1'b1;
        flush_expect();
        @(posedge clk);
        @(negedge clk);
        check_zero_outputs(tag);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        int guard;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom);
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.win_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        apply_reset("rst");

        // Frame 1: base 0, consumer always ready, full frame.
        start_frame(AW'(0));
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (bus.win_valid === 1'b1) break;
        end
        check("first_valid_cycle", 72'(n), 72'(11));
        check("first_pos", 72'({bus.win_row, bus.win_col}), 72'(0));
        while (bus.done !== 1'b1 && n < 60000) begin
            @(negedge clk);
            n++;
        end
        check("done_cycle", 72'(n), 72'(EXP_DONE + 1));
        @(negedge clk);
        check("busy_after_done", 72'(bus.busy), 72'(0));
        check("done_one_pulse", 72'(bus.done), 72'(0));
        check("win_count", 72'(win_cnt), 72'(NWIN));
        check("done_count", 72'(done_cnt), 72'(1));
        check("last_pos", 72'(last_pos), 72'({6'd57, 7'd77}));
        check("left_windows", 72'(exp_data_q.size()), 72'(0));
        check("left_reads", 72'(exp_addr_q.size()), 72'(0));
        for (int k = 0; k < 9; k++) check("w0_rd_addr", 72'(rd_log[k]), 72'(exp_first[k]));
        for (int k = 0; k < exp_second.size(); k++) check("w1_rd_addr", 72'(rd_log[9+k]), 72'(exp_second[k]));

        // Frame 2: base wraps the address space, stall first window, random ready, abort.
        bus.win_ready = 1'b0;
        start_frame(AW'(8190));
        n = 0;
        while (bus.win_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("stall_valid_cycle", 72'(n), 72'(11));
        for (int i = 0; i < 20; i++) begin
            check("stall_valid", 72'(bus.win_valid), 72'(1));
            check("stall_rd_en", 72'(bus.mem_rd_en), 72'(0));
            check("stall_data", bus.win_data, exp_data_q[0]);
            @(negedge clk);
        end
        for (int k = 0; k < 6; k++) check("wrap_rd_addr", 72'(rd_log[k]), 72'(exp_wrap[k]));
        @(posedge clk); #1;
        guard = 0;
        while (win_cnt < 100 && guard < 5000) begin
            bus.win_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            guard++;
        end
        check("frame2_progress", 72'(win_cnt >= 100), 72'(1));
        apply_reset("abort");

        // Frame 3: random base after abort, stray start while busy.
        start_frame(AW'($urandom));
        guard = 0;
        while (win_cnt < 60 && guard < 5000) begin
            bus.win_ready = ($urandom_range(0, 2) != 0);
            bus.start     = (guard == 30);
            bus.base_addr = AW'($urandom);
            @(posedge clk); #1;
            guard++;
        end
        bus.start = 1'b0;
        check("frame3_progress", 72'(win_cnt >= 60), 72'(1));
        check("frame3_busy", 72'(bus.busy), 72'(1));
        apply_reset("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
